serial_add_ctrl: RTL and testbench

- Bit-serial addition sequencer wrapped around the team's single-bit combinational full adder.
- Upstream role: accepts two WIDTH-bit operands and a carry-in, then drives the adder LSB-first through its a0/a1/c0 inputs.
- Downstream role: consumes the adder's s/c1 outputs, registers the carry between bits and assembles the WIDTH-bit sum plus final carry.
- One operation costs WIDTH+2 clock cycles.

---
 rtl/serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds an external combinational full adder LSB-first
// and collects its sum/carry into a WIDTH-bit result plus final carry.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  output logic             ready,
  output logic             fa_a0,
  output logic             fa_a1,
  output logic             fa_c0,
  input  logic             fa_s,
  input  logic             fa_c1,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: an operation is accepted on any rising edge where start=1 and
  // ready=1; start while ready=0 is dropped, never queued. Operands are
  // captured on that accept edge only, and done pulses once when sum/carry_out
  // hold the new result.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  assign last_bit  = (cnt == LAST_BIT);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_SHIFT;
      S_SHIFT: if (last_bit) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    fa_a0 = 1'b0;
    fa_a1 = 1'b0;
    fa_c0 = 1'b0;
    case (state)
      S_IDLE: ready = 1'b1;
      S_SHIFT: begin
        fa_a0 = a_sh[0];
        fa_a1 = b_sh[0];
        fa_c0 = cy;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // The adder is combinational, so fa_s/fa_c1 already reflect this cycle's bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh <= op_a;
            b_sh <= op_b;
            cy   <= carry_in;
            cnt  <= '0;
          end
        end
        S_SHIFT: begin
          res  <= {fa_s, res[WIDTH-1:1]};
          cy   <= fa_c1;
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            sum       <= {fa_s, res[WIDTH-1:1]};
            carry_out <= fa_c1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: an 8-bit instance for timing/handshake scenarios and
// a 3-bit instance for an exhaustive back-to-back sweep, each with a full adder model.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       start8, cin8, ready8, fa_a0_8, fa_a1_8, fa_c0_8, fa_s8, fa_c1_8, cout8, done8;
  logic [7:0] op_a8, op_b8, sum8;
  logic [1:0] st8;

  logic       start3, cin3, ready3, fa_a0_3, fa_a1_3, fa_c0_3, fa_s3, fa_c1_3, cout3, done3;
  logic [2:0] op_a3, op_b3, sum3;
  logic [1:0] st3;

  assign fa_s8   = fa_a0_8 ^ fa_a1_8 ^ fa_c0_8;
  assign fa_c1_8 = (fa_a0_8 & fa_a1_8) | (fa_a0_8 & fa_c0_8) | (fa_a1_8 & fa_c0_8);
  assign fa_s3   = fa_a0_3 ^ fa_a1_3 ^ fa_c0_3;
  assign fa_c1_3 = (fa_a0_3 & fa_a1_3) | (fa_a0_3 & fa_c0_3) | (fa_a1_3 & fa_c0_3);

  serial_add_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op_a(op_a8), .op_b(op_b8),
    .carry_in(cin8), .ready(ready8), .fa_a0(fa_a0_8), .fa_a1(fa_a1_8),
    .fa_c0(fa_c0_8), .fa_s(fa_s8), .fa_c1(fa_c1_8), .sum(sum8),
    .carry_out(cout8), .done(done8), .state_dbg(st8)
  );

  serial_add_ctrl #(.WIDTH(3)) u3 (
    .clk(clk), .reset(reset), .start(start3), .op_a(op_a3), .op_b(op_b3),
    .carry_in(cin3), .ready(ready3), .fa_a0(fa_a0_3), .fa_a1(fa_a1_3),
    .fa_c0(fa_c0_3), .fa_s(fa_s3), .fa_c1(fa_c1_3), .sum(sum3),
    .carry_out(cout3), .done(done3), .state_dbg(st3)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];
  logic [3:0] exp3_q[$];

  // Carry entering bit k of a+b+cin, computed arithmetically from the low k bits.
  function automatic logic exp_carry(input logic [7:0] a, input logic [7:0] b,
                                     input logic cin, input int k);
    logic [8:0] m;
    logic [9:0] s;
    m = 9'((9'd1 << k) - 9'd1);
    s = 10'(a & m[7:0]) + 10'(b & m[7:0]) + 10'(cin);
    return s[k];
  endfunction

  task automatic test_reset();
    reset = 1'b0; start8 = 1'b1; start3 = 1'b1;
    op_a8 = 8'hA5; op_b8 = 8'h5A; cin8 = 1'b1;
    op_a3 = 3'd5; op_b3 = 3'd6; cin3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({ready8, done8, cout8} !== 3'b100) begin
        n_bad++; $display("FAIL reset_ctrl8 edge %0d: ready/done/cout=%b want 100", i, {ready8, done8, cout8});
      end
      n_cmp++;
      if (sum8 !== 8'h00) begin
        n_bad++; $display("FAIL reset_sum8 edge %0d: got %h want 00", i, sum8);
      end
      n_cmp++;
      if ({fa_a0_8, fa_a1_8, fa_c0_8} !== 3'b000) begin
        n_bad++; $display("FAIL reset_fa8 edge %0d: got %b want 000", i, {fa_a0_8, fa_a1_8, fa_c0_8});
      end
      n_cmp++;
      if ({ready3, done3, cout3, sum3, fa_a0_3, fa_a1_3, fa_c0_3} !== 9'b100_000_000) begin
        n_bad++; $display("FAIL reset_u3 edge %0d: got %b want 100000000", i,
                          {ready3, done3, cout3, sum3, fa_a0_3, fa_a1_3, fa_c0_3});
      end
    end
    start8 = 1'b0; start3 = 1'b0; reset = 1'b1;
    exp_q.delete(); exp3_q.delete();
  endtask

  task automatic test_basic();
    logic [7:0] a, b;
    logic       c;
    logic [8:0] e;
    int         low;
    a = 8'h35; b = 8'h4A; c = 1'b0; low = 0;
    n_cmp++;
    if (ready8 !== 1'b1) begin
      n_bad++; $display("FAIL basic_ready_idle: got %b want 1", ready8);
    end
    op_a8 = a; op_b8 = b; cin8 = c; start8 = 1'b1;
    exp_q.push_back(9'h07F);
    @(posedge clk); #1;
    start8 = 1'b0; op_a8 = 8'hFF; op_b8 = 8'hFF; cin8 = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      if (!ready8) low++;
      if (k < 8) begin
        n_cmp++;
        if ({fa_a0_8, fa_a1_8, fa_c0_8} !== {a[k], b[k], exp_carry(a, b, c, k)}) begin
          n_bad++; $display("FAIL basic_fa bit %0d: got %b want %b", k,
                            {fa_a0_8, fa_a1_8, fa_c0_8}, {a[k], b[k], exp_carry(a, b, c, k)});
        end
      end
      n_cmp++;
      if (done8 !== (k == 8)) begin
        n_bad++; $display("FAIL basic_done cycle E+%0d: got %b want %b", k, done8, (k == 8));
      end
      if (done8) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL basic_result: unexpected done, nothing expected");
        end else begin
          e = exp_q.pop_front();
          if ({cout8, sum8} !== e) begin
            n_bad++; $display("FAIL basic_result: got %h want %h", {cout8, sum8}, e);
          end
        end
      end
      if (k < 9) begin
        @(posedge clk); #1;
      end
    end
    n_cmp++;
    if (low != 9 || ready8 !== 1'b1) begin
      n_bad++; $display("FAIL basic_ready_low: got %0d cycles ready=%b want 9 cycles ready=1", low, ready8);
    end
  endtask

  task automatic test_carry();
    logic [16:0] tbl [2];
    logic [7:0]  a, b;
    logic        c;
    logic [8:0]  e;
    bit          seen;
    tbl[0] = {8'hFF, 8'h01, 1'b0};
    tbl[1] = {8'hFF, 8'hFF, 1'b1};
    for (int t = 0; t < 2; t++) begin
      {a, b, c} = tbl[t];
      seen = 1'b0;
      op_a8 = a; op_b8 = b; cin8 = c; start8 = 1'b1;
      exp_q.push_back(9'(a) + 9'(b) + 9'(c));
      @(posedge clk); #1;
      start8 = 1'b0;
      for (int k = 0; k <= 9; k++) begin
        if (k < 8) begin
          n_cmp++;
          if (fa_c0_8 !== exp_carry(a, b, c, k)) begin
            n_bad++; $display("FAIL carry_fa_c0 op %0d bit %0d: got %b want %b", t, k, fa_c0_8, exp_carry(a, b, c, k));
          end
        end
        if (done8) begin
          seen = 1'b1;
          n_cmp++;
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
          if ({cout8, sum8} !== e || k != 8) begin
            n_bad++; $display("FAIL carry_result op %0d at E+%0d: got %h want %h at E+8", t, k, {cout8, sum8}, e);
          end
        end
        if (k < 9) begin
          @(posedge clk); #1;
        end
      end
      n_cmp++;
      if (!seen) begin
        n_bad++; $display("FAIL carry_done op %0d: got no done pulse want one", t);
      end
    end
  endtask

  task automatic test_handshake();
    logic [7:0] a1, b1, a2, b2;
    logic       c1, c2;
    logic [8:0] r1, e;
    a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255)); c1 = 1'($urandom_range(0, 1));
    r1 = 9'(a1) + 9'(b1) + 9'(c1);
    op_a8 = a1; op_b8 = b1; cin8 = c1; start8 = 1'b1;
    exp_q.push_back(r1);
    @(posedge clk); #1;
    for (int k = 0; k <= 18; k++) begin
      n_cmp++;
      if (ready8 !== (k == 9) || done8 !== (k == 8 || k == 18)) begin
        n_bad++; $display("FAIL hs_ctrl at E+%0d: ready/done=%b%b want %b%b", k, ready8, done8,
                          (k == 9), (k == 8 || k == 18));
      end
      if (done8) begin
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
        if ({cout8, sum8} !== e) begin
          n_bad++; $display("FAIL hs_result at E+%0d: got %h want %h", k, {cout8, sum8}, e);
        end
      end
      if (k >= 9 && k < 18) begin
        n_cmp++;
        if ({cout8, sum8} !== r1) begin
          n_bad++; $display("FAIL hs_sum_hold at E+%0d: got %h want %h", k, {cout8, sum8}, r1);
        end
      end
      if (k == 9) begin
        a2 = 8'($urandom_range(0, 255)); b2 = 8'($urandom_range(0, 255)); c2 = 1'($urandom_range(0, 1));
        op_a8 = a2; op_b8 = b2; cin8 = c2;
        exp_q.push_back(9'(a2) + 9'(b2) + 9'(c2));
      end else begin
        op_a8 = 8'($urandom_range(0, 255)); op_b8 = 8'($urandom_range(0, 255));
        cin8 = 1'($urandom_range(0, 1));
      end
      if (k == 18) start8 = 1'b0;
      if (k < 18) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int         ndone;
    bit         seen;
    logic [8:0] e;
    op_a8 = 8'h12; op_b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    n_cmp++;
    if ({ready8, done8, cout8, sum8, fa_a0_8, fa_a1_8, fa_c0_8} !== {3'b100, 8'h00, 3'b000}) begin
      n_bad++; $display("FAIL midreset_state: ready/done/cout/sum/fa=%b want 10000000000000",
                        {ready8, done8, cout8, sum8, fa_a0_8, fa_a1_8, fa_c0_8});
    end
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_bad++; $display("FAIL midreset_no_done: got %0d pulses want 0", ndone);
    end
    op_a8 = 8'h10; op_b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    exp_q.push_back(9'h030);
    @(posedge clk); #1;
    start8 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (done8) begin
        seen = 1'b1;
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
        if ({cout8, sum8} !== e) begin
          n_bad++; $display("FAIL midreset_after: got %h want %h", {cout8, sum8}, e);
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++; $display("FAIL midreset_timeout: got no done in 20 cycles want one");
    end
  endtask

  task automatic test_back_to_back();
    int         idx, ndone, cyc;
    logic [6:0] v;
    logic [3:0] e;
    idx = 0; ndone = 0; cyc = 0;
    while (ndone < 128 && cyc < 1000) begin
      if (done3) begin
        ndone++;
        n_cmp++;
        e = (exp3_q.size() != 0) ? exp3_q.pop_front() : 4'hF;
        if ({cout3, sum3} !== e) begin
          n_bad++; $display("FAIL b2b_result #%0d: got %h want %h", ndone, {cout3, sum3}, e);
        end
      end
      if (ready3) begin
        if (idx < 128) begin
          v = 7'(idx);
          op_a3 = v[6:4]; op_b3 = v[3:1]; cin3 = v[0]; start3 = 1'b1;
          exp3_q.push_back(4'(v[6:4]) + 4'(v[3:1]) + 4'(v[0]));
          idx++;
        end else begin
          start3 = 1'b0;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start3 = 1'b0;
    n_cmp++;
    if (ndone != 128 || exp3_q.size() != 0) begin
      n_bad++; $display("FAIL b2b_count: got %0d done pulses, %0d left want 128, 0", ndone, exp3_q.size());
    end
  endtask

  initial begin
    reset = 1'b0; start8 = 1'b0; start3 = 1'b0;
    op_a8 = '0; op_b8 = '0; cin8 = 1'b0;
    op_a3 = '0; op_b3 = '0; cin3 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
